// File: rtl/sentinel_pkg.sv
// Shared types and constants for the sentinel perimeter gate.
package sentinel_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned FAIL_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        AUTH    = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    // 7-seg glyphs, active-low {dp,g,f,e,d,c,b,a}
    localparam logic [BYTE_W-1:0] SEG_LOCKED   = 8'hC7;
    localparam logic [BYTE_W-1:0] SEG_UNLOCKED = 8'hC1;
    localparam logic [BYTE_W-1:0] SEG_OFF      = 8'hFF;
    localparam logic [BYTE_W-1:0] SEG_LOCKOUT  = 8'h86;
    localparam logic [BYTE_W-1:0] SEG_TAMPER   = 8'h8E;

    function automatic logic [FAIL_W-1:0] fail_sat_inc(input logic [FAIL_W-1:0] v);
        return (v == {FAIL_W{1'b1}}) ? v : v + FAIL_W'(1);
    endfunction

endpackage

// File: rtl/sentinel_seq_gate_if.sv
// Key/status pad bundle between the wrapper (master) and the gate (slave).
interface sentinel_seq_gate_if;
    import sentinel_pkg::*;

    logic              ena;
    logic [BYTE_W-1:0] key_in;
    logic              key_valid;
    logic              relock;
    logic              diag_sel;
    logic [BYTE_W-1:0] status_in;
    logic [BYTE_W-1:0] seg_out;
    logic [BYTE_W-1:0] status_out;
    logic [BYTE_W-1:0] status_oe;
    logic              authorized;
    logic              locked_out;
    logic              tamper;
    logic [FAIL_W-1:0] fail_count;

    modport master (
        output ena, key_in, key_valid, relock, diag_sel, status_in,
        input  seg_out, status_out, status_oe, authorized, locked_out, tamper, fail_count
    );

    modport slave (
        input  ena, key_in, key_valid, relock, diag_sel, status_in,
        output seg_out, status_out, status_oe, authorized, locked_out, tamper, fail_count
    );

endinterface

// File: rtl/sentinel_loopback_mon.sv
// Watches driven status against pad read-back; a sustained fight blows a sticky fuse.
module sentinel_loopback_mon #(
    parameter int unsigned FIGHT_CYCLES = 2,
    parameter int unsigned W            = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] drive,
    input  logic [W-1:0] readback,
    output logic         fuse
);

    localparam int unsigned CNT_W = $clog2(FIGHT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fuse_q, fuse_d;

    always_comb begin
        cnt_d  = cnt_q;
        fuse_d = fuse_q;
        if (drive == readback) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(FIGHT_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(FIGHT_CYCLES)) begin
            fuse_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            fuse_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fuse_q <= fuse_d;
        end
    end

    assign fuse = fuse_q;

endmodule

// File: rtl/sentinel_seq_gate.sv
// Perimeter gate: timed multi-byte challenge, fail counting, unescapable lockout
// and a loopback tamper fuse, with all pad outputs registered.
module sentinel_seq_gate
    import sentinel_pkg::*;
#(
    parameter int unsigned KEY_BYTES      = 4,
    parameter logic [63:0] KEY            = 64'h0000_0000_3CE1_5AB6,
    parameter int unsigned WIN_MIN        = 3,
    parameter int unsigned WIN_MAX        = 5,
    parameter int unsigned TIMEOUT        = 10,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100_000_000,
    parameter int unsigned FIGHT_CYCLES   = 2
) (
    input logic                clk,
    input logic                rst,
    sentinel_seq_gate_if.slave bus
);

    localparam int unsigned IDX_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned CYC_W  = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam int unsigned TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic              ena_prev_q, ena_prev_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    logic [BYTE_W-1:0] seg_out_q, seg_out_d;
    logic [BYTE_W-1:0] status_out_q, status_out_d;
    logic [BYTE_W-1:0] status_oe_q, status_oe_d;
    logic              authorized_q, authorized_d;
    logic              locked_out_q, locked_out_d;
    logic              tamper_q, tamper_d;
    logic [FAIL_W-1:0] fail_count_q, fail_count_d;

    logic              fuse;
    logic              arm_c;
    logic              in_win_c;
    logic              key_hit_c;
    logic              fail_evt_c;
    logic [FAIL_W-1:0] fail_inc_c;
    logic [BYTE_W-1:0] exp_byte_c;

    sentinel_loopback_mon #(
        .FIGHT_CYCLES (FIGHT_CYCLES),
        .W            (BYTE_W)
    ) u_loopback_mon (
        .clk      (clk),
        .rst      (rst),
        .drive    (status_out_q),
        .readback (bus.status_in),
        .fuse     (fuse)
    );

    // Next-state: fuse overrides everything, lockout ignores ena entirely.
    always_comb begin
        state_d    = state_q;
        ena_prev_d = bus.ena;
        cyc_d      = cyc_q;
        idx_d      = idx_q;
        fail_d     = fail_q;
        tmr_d      = tmr_q;
        fail_evt_c = 1'b0;

        arm_c      = bus.ena & ~ena_prev_q;
        in_win_c   = (cyc_q >= CYC_W'(WIN_MIN)) && (cyc_q <= CYC_W'(WIN_MAX));
        exp_byte_c = BYTE_W'(KEY >> {idx_q, 3'b000});
        key_hit_c  = (bus.key_in == exp_byte_c);
        fail_inc_c = fail_sat_inc(fail_q);

        if (fuse) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_c) begin
                        state_d = ARMED;
                        cyc_d   = '0;
                        idx_d   = '0;
                    end
                end
                ARMED: begin
                    if (cyc_q != {CYC_W{1'b1}}) begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                    if (!bus.ena) begin
                        state_d = IDLE;
                    end else if (bus.key_valid) begin
                        if (!in_win_c) begin
                            state_d = LOCKOUT;
                        end else if (key_hit_c) begin
                            if (idx_q == IDX_W'(KEY_BYTES - 1)) begin
                                state_d = AUTH;
                                fail_d  = '0;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                                cyc_d = '0;
                            end
                        end else begin
                            fail_evt_c = 1'b1;
                        end
                    end else if (cyc_q == CYC_W'(TIMEOUT)) begin
                        fail_evt_c = 1'b1;
                    end
                end
                AUTH: begin
                    if (!bus.ena || bus.relock || bus.key_valid) begin
                        state_d = IDLE;
                    end
                end
                LOCKOUT: begin
                    if (tmr_q == '0) begin
                        state_d = IDLE;
                        fail_d  = '0;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (fail_evt_c) begin
                fail_d  = fail_inc_c;
                state_d = (fail_inc_c >= FAIL_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
            end
            if (state_d == LOCKOUT && state_q != LOCKOUT) begin
                tmr_d = TMR_W'(LOCKOUT_CYCLES - 1);
            end
        end
    end

    // Pad outputs reflect the current registered state one cycle later.
    always_comb begin
        seg_out_d    = SEG_LOCKED;
        status_out_d = '0;
        status_oe_d  = 8'hFF;
        authorized_d = (state_q == AUTH) && !fuse;
        locked_out_d = (state_q == LOCKOUT);
        tamper_d     = fuse;
        fail_count_d = fail_q;

        if (!bus.ena) begin
            seg_out_d = SEG_OFF;
        end else if (fuse) begin
            seg_out_d = SEG_TAMPER;
        end else if (state_q == LOCKOUT) begin
            seg_out_d = SEG_LOCKOUT;
        end else if (state_q == AUTH) begin
            seg_out_d = SEG_UNLOCKED;
        end

        if (bus.diag_sel) begin
            status_out_d = {fuse, (state_q == LOCKOUT), fail_q, 3'(idx_q)};
        end else if ((state_q == AUTH) && bus.ena && !fuse) begin
            status_out_d = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ena_prev_q   <= 1'b0;
            cyc_q        <= '0;
            idx_q        <= '0;
            fail_q       <= '0;
            tmr_q        <= '0;
            seg_out_q    <= SEG_OFF;
            status_out_q <= '0;
            status_oe_q  <= 8'hFF;
            authorized_q <= 1'b0;
            locked_out_q <= 1'b0;
            tamper_q     <= 1'b0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ena_prev_q   <= ena_prev_d;
            cyc_q        <= cyc_d;
            idx_q        <= idx_d;
            fail_q       <= fail_d;
            tmr_q        <= tmr_d;
            seg_out_q    <= seg_out_d;
            status_out_q <= status_out_d;
            status_oe_q  <= status_oe_d;
            authorized_q <= authorized_d;
            locked_out_q <= locked_out_d;
            tamper_q     <= tamper_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign bus.seg_out    = seg_out_q;
    assign bus.status_out = status_out_q;
    assign bus.status_oe  = status_oe_q;
    assign bus.authorized = authorized_q;
    assign bus.locked_out = locked_out_q;
    assign bus.tamper     = tamper_q;
    assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_sentinel_seq_gate.sv
// Directed bench for sentinel_seq_gate: 2-byte key B6 then 5A, short lockout.
module tb_sentinel_seq_gate;
    import sentinel_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic       fight_en  = 1'b0;
    logic [7:0] fight_val = 8'h00;

    always #5 clk = ~clk;

    sentinel_seq_gate_if bus ();

    // Pads loop status_out back unless a fight is being injected
    assign bus.status_in = fight_en ? fight_val : bus.status_out;

    sentinel_seq_gate #(
        .KEY_BYTES      (2),
        .KEY            (64'h0000_0000_0000_5AB6),
        .WIN_MIN        (3),
        .WIN_MAX        (5),
        .TIMEOUT        (10),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (20),
        .FIGHT_CYCLES   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.ena       = 1'b0;
        bus.key_in    = 8'h00;
        bus.key_valid = 1'b0;
        bus.relock    = 1'b0;
        bus.diag_sel  = 1'b0;
        fight_en      = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Returns just after the edge that enters ARMED with cyc=0
    task automatic arm();
        bus.ena = 1'b0;
        tick();
        bus.ena = 1'b1;
        tick();
    endtask

    // Presents byte b on the edge where cyc equals k
    task automatic send_byte(input logic [7:0] b, input int k);
        repeat (k) tick();
        bus.key_in    = b;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        vectors++; if (bus.seg_out !== 8'hFF) begin miscompares++; $display("FAIL reset_seg got %h want ff", bus.seg_out); end
        vectors++; if (bus.status_out !== 8'h00) begin miscompares++; $display("FAIL reset_status got %h want 00", bus.status_out); end
        vectors++; if (bus.status_oe !== 8'hFF) begin miscompares++; $display("FAIL reset_oe got %h want ff", bus.status_oe); end
        vectors++; if ({bus.authorized, bus.locked_out, bus.tamper} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {bus.authorized, bus.locked_out, bus.tamper}); end
        vectors++; if (bus.fail_count !== 3'd0) begin miscompares++; $display("FAIL reset_fail got %0d want 0", bus.fail_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_auth_and_relock();
        do_reset();
        arm();
        send_byte(8'hB6, 3);
        send_byte(8'h5A, 4);
        tick();
        vectors++; if (bus.authorized !== 1'b1) begin miscompares++; $display("FAIL auth_flag got %b want 1", bus.authorized); end
        vectors++; if (bus.seg_out !== 8'hC1) begin miscompares++; $display("FAIL auth_seg got %h want c1", bus.seg_out); end
        vectors++; if (bus.status_out !== 8'hFF) begin miscompares++; $display("FAIL auth_status got %h want ff", bus.status_out); end
        vectors++; if (bus.fail_count !== 3'd0) begin miscompares++; $display("FAIL auth_fail got %0d want 0", bus.fail_count); end
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
        tick();
        vectors++; if (bus.authorized !== 1'b0) begin miscompares++; $display("FAIL relock_flag got %b want 0", bus.authorized); end
        vectors++; if (bus.seg_out !== 8'hC7) begin miscompares++; $display("FAIL relock_seg got %h want c7", bus.seg_out); end
    endtask

    task automatic test_replay_lockout();
        do_reset();
        arm();
        send_byte(8'hB6, 0);
        tick();
        vectors++; if (bus.locked_out !== 1'b1) begin miscompares++; $display("FAIL replay_locked got %b want 1", bus.locked_out); end
        vectors++; if (bus.seg_out !== 8'h86) begin miscompares++; $display("FAIL replay_seg got %h want 86", bus.seg_out); end
        bus.ena = 1'b0; tick();
        bus.ena = 1'b1; tick();
        bus.ena = 1'b0; tick();
        bus.ena = 1'b1;
        repeat (16) tick();
        vectors++; if (bus.locked_out !== 1'b1) begin miscompares++; $display("FAIL lockout_hold got %b want 1", bus.locked_out); end
        tick();
        vectors++; if (bus.locked_out !== 1'b0) begin miscompares++; $display("FAIL lockout_expire got %b want 0", bus.locked_out); end
        vectors++; if (bus.seg_out !== 8'hC7) begin miscompares++; $display("FAIL lockout_exit_seg got %h want c7", bus.seg_out); end
    endtask

    task automatic test_fail_lockout();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            arm();
            send_byte(8'h00, 4);
            tick();
            tick();
            vectors++; if (bus.fail_count !== 3'(i)) begin miscompares++; $display("FAIL fail_count_%0d got %0d want %0d", i, bus.fail_count, i); end
            vectors++; if (bus.locked_out !== (i == 3)) begin miscompares++; $display("FAIL fail_locked_%0d got %b want %b", i, bus.locked_out, (i == 3)); end
        end
        repeat (22) tick();
        vectors++; if (bus.fail_count !== 3'd0) begin miscompares++; $display("FAIL fail_clear got %0d want 0", bus.fail_count); end
        vectors++; if (bus.locked_out !== 1'b0) begin miscompares++; $display("FAIL fail_unlock got %b want 0", bus.locked_out); end
    endtask

    task automatic test_timeout();
        do_reset();
        arm();
        repeat (11) tick();
        vectors++; if (bus.fail_count !== 3'd0) begin miscompares++; $display("FAIL timeout_early got %0d want 0", bus.fail_count); end
        tick();
        vectors++; if (bus.fail_count !== 3'd1) begin miscompares++; $display("FAIL timeout_fail got %0d want 1", bus.fail_count); end
        vectors++; if (bus.locked_out !== 1'b0) begin miscompares++; $display("FAIL timeout_locked got %b want 0", bus.locked_out); end
    endtask

    task automatic test_window_edges();
        do_reset();
        arm();
        send_byte(8'hB6, 5);
        bus.diag_sel = 1'b1;
        tick();
        tick();
        vectors++; if (bus.status_out !== 8'h01) begin miscompares++; $display("FAIL win_max_accept got %h want 01", bus.status_out); end
        send_byte(8'h5A, 4);
        tick();
        vectors++; if (bus.status_out !== 8'h41) begin miscompares++; $display("FAIL win_late_diag got %h want 41", bus.status_out); end
        vectors++; if (bus.seg_out !== 8'h86) begin miscompares++; $display("FAIL win_late_seg got %h want 86", bus.seg_out); end
        bus.diag_sel = 1'b0;
    endtask

    task automatic test_diag_async_rst();
        do_reset();
        arm();
        send_byte(8'h00, 4);
        arm();
        send_byte(8'hB6, 3);
        bus.diag_sel = 1'b1;
        tick();
        tick();
        vectors++; if (bus.status_out !== 8'b0000_1001) begin miscompares++; $display("FAIL diag_word got %b want 00001001", bus.status_out); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (bus.seg_out !== 8'hFF) begin miscompares++; $display("FAIL arst_seg got %h want ff", bus.seg_out); end
        vectors++; if (bus.status_out !== 8'h00) begin miscompares++; $display("FAIL arst_status got %h want 00", bus.status_out); end
        vectors++; if (bus.fail_count !== 3'd0) begin miscompares++; $display("FAIL arst_fail got %0d want 0", bus.fail_count); end
        vectors++; if ({bus.authorized, bus.locked_out, bus.tamper} !== 3'b000) begin miscompares++; $display("FAIL arst_flags got %b want 000", {bus.authorized, bus.locked_out, bus.tamper}); end
        tick();
        rst = 1'b0;
        bus.diag_sel = 1'b0;
    endtask

    task automatic test_tamper();
        do_reset();
        arm();
        send_byte(8'hB6, 3);
        send_byte(8'h5A, 4);
        tick();
        vectors++; if (bus.authorized !== 1'b1) begin miscompares++; $display("FAIL tamper_pre_auth got %b want 1", bus.authorized); end
        fight_val = 8'h00;
        fight_en  = 1'b1;
        tick();
        tick();
        fight_en = 1'b0;
        tick();
        vectors++; if (bus.tamper !== 1'b1) begin miscompares++; $display("FAIL tamper_flag got %b want 1", bus.tamper); end
        vectors++; if (bus.authorized !== 1'b0) begin miscompares++; $display("FAIL tamper_auth got %b want 0", bus.authorized); end
        vectors++; if (bus.seg_out !== 8'h8E) begin miscompares++; $display("FAIL tamper_seg got %h want 8e", bus.seg_out); end
        arm();
        send_byte(8'hB6, 3);
        send_byte(8'h5A, 4);
        tick();
        tick();
        vectors++; if (bus.authorized !== 1'b0) begin miscompares++; $display("FAIL tamper_retry_auth got %b want 0", bus.authorized); end
        vectors++; if (bus.seg_out !== 8'h8E) begin miscompares++; $display("FAIL tamper_retry_seg got %h want 8e", bus.seg_out); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.tamper !== 1'b0) begin miscompares++; $display("FAIL tamper_rst got %b want 0", bus.tamper); end
        vectors++; if (bus.seg_out !== 8'hFF) begin miscompares++; $display("FAIL tamper_rst_seg got %h want ff", bus.seg_out); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (bus.seg_out !== 8'hC7) begin miscompares++; $display("FAIL post_rst_seg got %h want c7", bus.seg_out); end
    endtask

    initial begin
        bus.ena       = 1'b0;
        bus.key_in    = 8'h00;
        bus.key_valid = 1'b0;
        bus.relock    = 1'b0;
        bus.diag_sel  = 1'b0;
        test_reset();
        test_auth_and_relock();
        test_replay_lockout();
        test_fail_lockout();
        test_timeout();
        test_window_edges();
        test_diag_async_rst();
        test_tamper();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
